// File: rtl/recv_init_draw_pkg.sv
// recv_init_draw_pkg: shared player, game-state and message encodings for the initial-draw receive path
package recv_init_draw_pkg;
  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam logic [3:0] P1_INIT_DRAW = 4'd1;
  localparam logic [3:0] P2_INIT_DRAW = 4'd2;
  localparam logic [3:0] MSG_STATE_CHANGE = 4'd1;
  localparam logic [3:0] MSG_DRAW_CARD = 4'd3;
  typedef enum logic [1:0] {IDLE, RECV, DONE, WAIT_EXIT} state_t;
endpackage

// File: rtl/recv_init_draw_card_dup_tracker.sv
// recv_init_draw_card_dup_tracker: per-card-id copy counters answering "fewer than two copies seen"
module recv_init_draw_card_dup_tracker #(
  parameter int CARD_NUM = 54
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic [5:0] idx,
  output logic       ok
);
  logic [1:0] cnt [CARD_NUM];
  assign ok = (idx < 6'(CARD_NUM)) && (cnt[idx] < 2'd2);
  // clear all ids together; bump one id per accepted card
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '{default: '0};
    else if (clr) cnt <= '{default: '0};
    else if (inc) cnt[idx] <= cnt[idx] + 2'd1;
endmodule

// File: rtl/recv_init_draw.sv
// recv_init_draw: consumes the opponent's initial DRAW_CARD messages, removes them from the deck and counts the hand
module recv_init_draw
  import recv_init_draw_pkg::*;
#(
  parameter int PLAYER = P1,
  parameter int INIT_CARDS = 14,
  parameter int CARD_NUM = 54
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       interboard_rst,
  input  logic [3:0] cur_game_state,
  input  logic       interboard_en,
  input  logic [3:0] interboard_msg_type,
  input  logic [5:0] interboard_card,
  output logic       deck_take_en,
  output logic [5:0] deck_take_card,
  output logic [4:0] opp_hand_cnt,
  output logic       init_draw_recv_done,
  output logic       init_draw_err
);
  localparam logic [4:0] init_lim = 5'(INIT_CARDS);
  state_t state;
  logic active, take, clr, ok;
  assign active = (PLAYER == P1 && cur_game_state == P2_INIT_DRAW) ||
                  (PLAYER == P2 && cur_game_state == P1_INIT_DRAW);
  assign take = state == RECV && active && interboard_en &&
                interboard_msg_type == MSG_DRAW_CARD && ok && opp_hand_cnt < init_lim;
  assign clr = interboard_rst || (state == IDLE && active);
  recv_init_draw_card_dup_tracker #(.CARD_NUM(CARD_NUM)) u_dup (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .inc(take),
    .idx(interboard_card),
    .ok(ok)
  );
  // phase sequencing; the count and id tracker update on the accepting edge so back-to-back cards see fresh state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      deck_take_en <= 1'b0;
      deck_take_card <= '0;
      opp_hand_cnt <= '0;
      init_draw_recv_done <= 1'b0;
      init_draw_err <= 1'b0;
    end else if (interboard_rst) begin
      state <= IDLE;
      deck_take_en <= 1'b0;
      deck_take_card <= '0;
      opp_hand_cnt <= '0;
      init_draw_recv_done <= 1'b0;
      init_draw_err <= 1'b0;
    end else begin
      deck_take_en <= take;
      init_draw_recv_done <= 1'b0;
      if (take) begin
        deck_take_card <= interboard_card;
        opp_hand_cnt <= opp_hand_cnt + 5'd1;
      end
      case (state)
        IDLE: if (active) begin
          state <= RECV;
          opp_hand_cnt <= '0;
          init_draw_err <= 1'b0;
        end
        RECV: if (!active) state <= IDLE;
        else if (interboard_en) begin
          if (interboard_msg_type == MSG_STATE_CHANGE) begin
            state <= DONE;
            init_draw_recv_done <= 1'b1;
            init_draw_err <= init_draw_err || opp_hand_cnt != init_lim;
          end else if (!take) init_draw_err <= 1'b1;
        end
        DONE: state <= WAIT_EXIT;
        WAIT_EXIT: if (!active) state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_recv_init_draw.sv
// tb_recv_init_draw: randomized and directed checks of recv_init_draw against a behavioural model
module tb_recv_init_draw;
  import recv_init_draw_pkg::*;
  logic clk = 0, rst = 1, ibr = 0, en = 0;
  logic [3:0] cur = 0, mt = 0;
  logic [5:0] card = 0;
  logic take_en, done, err;
  logic [5:0] take_card;
  logic [4:0] hand_cnt;
  int vectors = 0, miscompares = 0;
  int take_n = 0, done_n = 0;
  int ph = 0, hand = 0, m_card = 0, cp [64];
  bit m_take = 0, m_done = 0, m_err = 0, m_act;

  recv_init_draw #(.PLAYER(P1), .INIT_CARDS(14), .CARD_NUM(54)) dut (
    .clk(clk),
    .rst(rst),
    .interboard_rst(ibr),
    .cur_game_state(cur),
    .interboard_en(en),
    .interboard_msg_type(mt),
    .interboard_card(card),
    .deck_take_en(take_en),
    .deck_take_card(take_card),
    .opp_hand_cnt(hand_cnt),
    .init_draw_recv_done(done),
    .init_draw_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", n, a, e, $time);
    end
  endtask

  // Reference: phase 0 waiting, 1 receiving, 2 done cycle, 3 waiting for the opponent to leave INIT_DRAW
  always @(posedge clk or posedge rst) begin
    if (rst || ibr) begin
      ph = 0; hand = 0; m_card = 0; m_take = 0; m_done = 0; m_err = 0;
      foreach (cp[i]) cp[i] = 0;
    end else begin
      m_act = cur == P2_INIT_DRAW;
      m_take = 0;
      m_done = 0;
      if (ph == 0) begin
        if (m_act) begin
          ph = 1; hand = 0; m_err = 0;
          foreach (cp[i]) cp[i] = 0;
        end
      end else if (ph == 1) begin
        if (!m_act) ph = 0;
        else if (en) begin
          if (mt == MSG_DRAW_CARD && card < 54 && cp[card] < 2 && hand < 14) begin
            m_take = 1; m_card = card; hand++; cp[card]++;
          end else if (mt == MSG_STATE_CHANGE) begin
            m_done = 1; m_err = m_err | (hand != 14); ph = 2;
          end else m_err = 1;
        end
      end else if (ph == 2) ph = 3;
      else if (!m_act) ph = 0;
    end
  end

  // Every cycle: outputs against the model, plus pulse tallies for the directed checks
  always @(negedge clk) begin
    chk("deck_take_en", take_en, m_take);
    chk("deck_take_card", take_card, m_card);
    chk("opp_hand_cnt", hand_cnt, hand);
    chk("done", done, m_done);
    chk("err", err, m_err);
    take_n += take_en;
    done_n += done;
  end

  task automatic send(input logic [3:0] t, input logic [5:0] c, input int gap);
    en = 1; mt = t; card = c;
    @(negedge clk);
    en = 0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic enter();
    cur = 0;
    repeat (2) @(negedge clk);
    cur = P2_INIT_DRAW;
    @(negedge clk);
  endtask

  int t0, d0;
  initial begin
    repeat (2) @(negedge clk);
    chk("reset take_en", take_en, 0);
    chk("reset hand", hand_cnt, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    rst = 0;
    // full spaced draw
    enter(); t0 = take_n; d0 = done_n;
    for (int i = 0; i < 14; i++) send(MSG_DRAW_CARD, 6'(i), 2);
    send(MSG_STATE_CHANGE, 0, 3);
    chk("spaced takes", take_n - t0, 14);
    chk("spaced hand", hand_cnt, 14);
    chk("spaced done", done_n - d0, 1);
    chk("spaced err", err, 0);
    // back-to-back draw
    enter(); t0 = take_n; d0 = done_n;
    for (int i = 0; i < 14; i++) send(MSG_DRAW_CARD, 6'(40 + i), 0);
    send(MSG_STATE_CHANGE, 0, 3);
    chk("b2b takes", take_n - t0, 14);
    chk("b2b done", done_n - d0, 1);
    chk("b2b err", err, 0);
    // third copy of one id
    enter(); t0 = take_n;
    repeat (3) send(MSG_DRAW_CARD, 6'd5, 1);
    chk("dup takes", take_n - t0, 2);
    chk("dup hand", hand_cnt, 2);
    chk("dup err", err, 1);
    // out-of-range id
    enter(); t0 = take_n;
    send(MSG_DRAW_CARD, 6'd60, 2);
    chk("id60 takes", take_n - t0, 0);
    chk("id60 err", err, 1);
    // early state change
    enter(); d0 = done_n;
    for (int i = 0; i < 10; i++) send(MSG_DRAW_CARD, 6'(20 + i), 0);
    send(MSG_STATE_CHANGE, 0, 3);
    chk("early err", err, 1);
    chk("early done", done_n - d0, 1);
    chk("early hand", hand_cnt, 10);
    // async reset between edges
    enter();
    for (int i = 0; i < 7; i++) send(MSG_DRAW_CARD, 6'(i), 0);
    #2 rst = 1;
    #1 chk("async hand", hand_cnt, 0);
    chk("async take_en", take_en, 0);
    @(negedge clk); rst = 0;
    // own init draw is not ours to receive
    cur = P1_INIT_DRAW; t0 = take_n; d0 = done_n;
    @(negedge clk);
    for (int i = 0; i < 5; i++) send(MSG_DRAW_CARD, 6'(i), 0);
    send(MSG_STATE_CHANGE, 0, 2);
    chk("p1 takes", take_n - t0, 0);
    chk("p1 done", done_n - d0, 0);
    // randomized rounds
    for (int r = 0; r < 8; r++) begin
      int n;
      enter();
      n = $urandom_range(8, 17);
      for (int i = 0; i < n; i++) begin
        logic [3:0] t;
        logic [5:0] c;
        t = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : MSG_DRAW_CARD;
        c = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 53));
        if (t == MSG_STATE_CHANGE) t = MSG_DRAW_CARD;
        if (r == 3 && i == 5) cur = 0;
        if (r == 5 && i == 6) begin ibr = 1; @(negedge clk); ibr = 0; end
        send(t, c, $urandom_range(0, 2));
      end
      send(MSG_STATE_CHANGE, 0, 3);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
